// File: rtl/ddr2_inj_pkg.sv
// Shared types for the DDR2 pattern injector: controller command codes, FSM states,
// the pattern-memory entry layout at default widths, and command classification.
package ddr2_inj_pkg;

   localparam int ADDR_W_DEF = 25;
   localparam int DATA_W_DEF = 16;
   localparam int WAIT_W_DEF = 8;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_SCR  = 3'd1,
      CMD_SCW  = 3'd2,
      CMD_BLR  = 3'd3,
      CMD_BLW  = 3'd4,
      CMD_ATR  = 3'd5,
      CMD_ATW  = 3'd6,
      CMD_NOP7 = 3'd7
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_ISSUE,
      ST_BLKFETCH,
      ST_BLKDATA,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [WAIT_W_DEF-1:0] wait_cyc;
      cmd_e                  cmd;
      logic [1:0]            sz;
      logic [2:0]            op;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
      logic                  fetching;
   } entry_t;

   // Commands that push a word into the controller data FIFO.
   function automatic logic needs_data(cmd_e c);
      return (c == CMD_SCW) || (c == CMD_BLW) || (c == CMD_ATR) || (c == CMD_ATW);
   endfunction

endpackage

// File: rtl/ddr2_inj_patmem.sv
// Pattern memory: DEPTH x WIDTH RAM with one write port and a registered read port.
module ddr2_inj_patmem #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 58
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ddr2_pattern_injector.sv
// Replays a preloaded command program into the ddr2_controller host port.
// Optional statistics counters are built when DDR2_INJ_STATS_EN is defined.
module ddr2_pattern_injector
   import ddr2_inj_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int DEPTH        = 256,
   parameter int WAIT_W       = WAIT_W_DEF,
   parameter int FILL_W       = 7,
   parameter int DATA_HI_MARK = 63,
   parameter int LOOP_W       = 8
) (
   input  logic                               CLK,
   input  logic                               RESETBAR,
   input  logic                               READY,
   input  logic                               START,
   input  logic [$clog2(DEPTH):0]             NUM_ENTRIES,
   input  logic [LOOP_W-1:0]                  LOOPS,
   input  logic                               LD_WE,
   input  logic [$clog2(DEPTH)-1:0]           LD_IDX,
   input  logic [WAIT_W+9+ADDR_W+DATA_W-1:0]  LD_ENTRY,
   input  logic                               NOTFULL,
   input  logic [FILL_W-1:0]                  FILLCOUNT,
   output logic [2:0]                         CMD,
   output logic [1:0]                         SZ,
   output logic [2:0]                         OP,
   output logic [ADDR_W-1:0]                  ADDR,
   output logic [DATA_W-1:0]                  DIN,
   output logic                               FETCHING,
   output logic                               BUSY,
   output logic                               DONE,
   output logic                               ERR
`ifdef DDR2_INJ_STATS_EN
   ,
   output logic [31:0]                        STAT_ISSUED,
   output logic [31:0]                        STAT_STALL
`endif
);

   localparam int IDX_W    = $clog2(DEPTH);
   localparam int ENTRY_W  = WAIT_W + 9 + ADDR_W + DATA_W;
   localparam int OFF_DATA = 1;
   localparam int OFF_ADDR = OFF_DATA + DATA_W;
   localparam int OFF_OP   = OFF_ADDR + ADDR_W;
   localparam int OFF_SZ   = OFF_OP + 3;
   localparam int OFF_CMD  = OFF_SZ + 2;
   localparam int OFF_WAIT = OFF_CMD + 3;

   localparam logic [IDX_W:0]    DEPTH_N  = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]    IDX_ONE  = (IDX_W+1)'(1);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
   localparam logic [LOOP_W-1:0] LOOP_ONE = LOOP_W'(1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W:0]      num_q, num_d;
   logic [LOOP_W-1:0]   loops_q, loops_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [4:0]          rem_q, rem_d;
   cmd_e                cmd_q, cmd_d;
   logic [1:0]          sz_q, sz_d;
   logic [2:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                fetching_q, fetching_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [ENTRY_W-1:0]  rdata;
   logic [WAIT_W-1:0]   ent_wait;
   cmd_e                ent_cmd;
   logic [1:0]          ent_sz;
   logic [2:0]          ent_op;
   logic [ADDR_W-1:0]   ent_addr;
   logic [DATA_W-1:0]   ent_data;
   logic                ent_fetch;
   logic                ent_nop;
   logic [IDX_W:0]      idx_nxt;
   logic                data_ok, cmd_ok, cmd_nop, start_go;
   logic                load_entry, advance, block_step, go_done;

   ddr2_inj_patmem #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_patmem (
      .clk   (CLK),
      .we    (LD_WE && !busy_q),
      .waddr (LD_IDX),
      .wdata (LD_ENTRY),
      .raddr (idx_d),
      .rdata (rdata)
   );

   assign ent_wait  = rdata[OFF_WAIT +: WAIT_W];
   assign ent_cmd   = cmd_e'(rdata[OFF_CMD +: 3]);
   assign ent_sz    = rdata[OFF_SZ +: 2];
   assign ent_op    = rdata[OFF_OP +: 3];
   assign ent_addr  = rdata[OFF_ADDR +: ADDR_W];
   assign ent_data  = rdata[OFF_DATA +: DATA_W];
   assign ent_fetch = rdata[0];
   assign ent_nop   = (ent_cmd == CMD_NOP) || (ent_cmd == CMD_NOP7);

   assign idx_nxt  = {1'b0, idx_q} + IDX_ONE;
   assign data_ok  = FILLCOUNT <= FILL_W'(DATA_HI_MARK);
   assign cmd_nop  = (cmd_q == CMD_NOP) || (cmd_q == CMD_NOP7);
   assign cmd_ok   = cmd_nop ? 1'b1 : (needs_data(cmd_q) ? (NOTFULL && data_ok) : NOTFULL);
   assign start_go = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && START && READY;

`ifdef DDR2_INJ_STATS_EN
   logic [31:0] stat_issued_q, stat_issued_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_issued_d = stat_issued_q;
      stat_stall_d  = stat_stall_q;
      if (start_go) begin
         stat_issued_d = '0;
         stat_stall_d  = '0;
      end else begin
         if ((state_q == ST_ISSUE) && cmd_ok && !cmd_nop && (stat_issued_q != '1)) begin
            stat_issued_d = stat_issued_q + 32'd1;
         end
         if ((((state_q == ST_ISSUE) && !cmd_ok) || ((state_q == ST_BLKDATA) && !data_ok))
             && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETBAR) begin
      if (!RESETBAR) begin
         stat_issued_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         stat_issued_q <= stat_issued_d;
         stat_stall_q  <= stat_stall_d;
      end
   end

   assign STAT_ISSUED = stat_issued_q;
   assign STAT_STALL  = stat_stall_q;
`endif

   // Outputs are registered, so every field is computed for the state being entered.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      num_d      = num_q;
      loops_d    = loops_q;
      wait_d     = wait_q;
      rem_d      = rem_q;
      cmd_d      = CMD_NOP;
      sz_d       = sz_q;
      op_d       = op_q;
      addr_d     = addr_q;
      din_d      = din_q;
      fetching_d = fetching_q;
      err_d      = err_q;
      load_entry = 1'b0;
      advance    = 1'b0;
      block_step = 1'b0;
      go_done    = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_go) begin
               num_d   = (NUM_ENTRIES > DEPTH_N) ? DEPTH_N : NUM_ENTRIES;
               loops_d = LOOPS;
               err_d   = 1'b0;
               idx_d   = '0;
               state_d = ST_FETCH;
               if (NUM_ENTRIES == '0) begin
                  go_done = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            if (ent_wait != '0) begin
               wait_d  = ent_wait;
               state_d = ST_WAIT;
            end else begin
               load_entry = 1'b1;
            end
         end
         ST_WAIT: begin
            if (wait_q == WAIT_ONE) begin
               load_entry = 1'b1;
            end else begin
               wait_d = wait_q - WAIT_ONE;
            end
         end
         ST_ISSUE: begin
            if (!cmd_ok) begin
               cmd_d = cmd_q;
            end else if (cmd_q == CMD_BLW) begin
               rem_d      = {sz_q, 3'b111};
               block_step = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         ST_BLKFETCH: begin
            din_d   = ent_data;
            state_d = ST_BLKDATA;
         end
         ST_BLKDATA: begin
            if (data_ok) begin
               rem_d = rem_q - 5'd1;
               if (rem_q == 5'd1) begin
                  advance = 1'b1;
               end else begin
                  block_step = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_entry) begin
         state_d    = ST_ISSUE;
         cmd_d      = ent_cmd;
         sz_d       = ((ent_cmd == CMD_BLR) || (ent_cmd == CMD_BLW)) ? ent_sz : 2'b00;
         op_d       = ((ent_cmd == CMD_ATR) || (ent_cmd == CMD_ATW)) ? ent_op : 3'b000;
         addr_d     = ent_nop ? '0 : ent_addr;
         din_d      = needs_data(ent_cmd) ? ent_data : '0;
         fetching_d = ent_fetch;
      end

      if (advance) begin
         if (idx_nxt == num_q) begin
            if (loops_q != '0) begin
               loops_d = loops_q - LOOP_ONE;
               idx_d   = '0;
               state_d = ST_FETCH;
            end else begin
               go_done = 1'b1;
            end
         end else begin
            idx_d   = idx_nxt[IDX_W-1:0];
            state_d = ST_FETCH;
         end
      end

      // A block whose data words run past the end of the program is flagged and abandoned.
      if (block_step) begin
         if (idx_nxt == num_q) begin
            err_d   = 1'b1;
            go_done = 1'b1;
         end else begin
            idx_d   = idx_nxt[IDX_W-1:0];
            state_d = ST_BLKFETCH;
         end
      end

      if (go_done) begin
         state_d    = ST_DONE;
         fetching_d = 1'b1;
      end

      busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge CLK or negedge RESETBAR) begin
      if (!RESETBAR) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         num_q      <= '0;
         loops_q    <= '0;
         wait_q     <= '0;
         rem_q      <= '0;
         cmd_q      <= CMD_NOP;
         sz_q       <= '0;
         op_q       <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         fetching_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         num_q      <= num_d;
         loops_q    <= loops_d;
         wait_q     <= wait_d;
         rem_q      <= rem_d;
         cmd_q      <= cmd_d;
         sz_q       <= sz_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         fetching_q <= fetching_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign CMD      = cmd_q;
   assign SZ       = sz_q;
   assign OP       = op_q;
   assign ADDR     = addr_q;
   assign DIN      = din_q;
   assign FETCHING = fetching_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ERR      = err_q;

endmodule
